// File: rtl/ifx_dig_data_bus_capture.sv
// Data-bus capture: samples a DWIDTH-wide bus every clock, records each value
// change (and the value present when capture is enabled) together with a
// free-running timestamp, and presents the entries through a first-word
// fall-through FIFO on a valid/ready port. Drops on full set a sticky flag.
module ifx_dig_data_bus_capture #(
   parameter int DWIDTH  = 1,
   parameter int DEPTH   = 8,
   parameter int TSWIDTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic [DWIDTH-1:0]          data_i,
   input  logic                       enable_i,
   input  logic                       clear_ovf_i,
   input  logic                       out_ready_i,
   output logic                       out_valid_o,
   output logic [DWIDTH-1:0]          out_data_o,
   output logic [TSWIDTH-1:0]         out_ts_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o,
   output logic                       overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef struct packed {
      logic [DWIDTH-1:0]  data;
      logic [TSWIDTH-1:0] ts;
   } entry_t;

   entry_t             mem [DEPTH];
   entry_t             head;
   logic [DWIDTH-1:0]  data_q;
   logic               enable_q;
   logic [TSWIDTH-1:0] ts_cnt;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [CW-1:0]      count;
   logic [CW-1:0]      count_nxt;
   logic               overflow_q;
   logic               evt;
   logic               full;
   logic               pop;
   logic               push;
   logic               drop;

   // Event detection and FIFO handshake decode. A start event pushes the
   // current bus value even if it equals the stale sample in data_q.
   always_comb begin
      evt  = 1'b0;
      full = (count == DEPTH_C);
      pop  = (count != '0) && out_ready_i;
      if (enable_i) begin
         evt = !enable_q || (data_i != data_q);
      end
      // A pop on the same edge frees the slot the push needs.
      push = evt && (!full || pop);
      drop = evt && full && !pop;
   end

   // Occupancy next value; simultaneous push and pop cancel out.
   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   // Bus/enable sampling and timestamp run every clock, regardless of enable,
   // so changes made while disabled are never reported later.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         data_q   <= '0;
         enable_q <= 1'b0;
         ts_cnt   <= '0;
      end else begin
         data_q   <= data_i;
         enable_q <= enable_i;
         ts_cnt   <= ts_cnt + TSWIDTH'(1);
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW).
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
      end
   end

   // Entry storage; contents are don't-care while unoccupied, so no reset.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= '{data: data_i, ts: ts_cnt};
   end

   // Sticky overflow: a drop on the same edge as a clear keeps the flag set.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end else if (clear_ovf_i) begin
         overflow_q <= 1'b0;
      end
   end

   // Fall-through head; forced to zero while empty. A push never targets
   // rd_ptr while entries are held, so the head is stable until popped.
   always_comb begin
      head        = mem[rd_ptr];
      out_valid_o = (count != '0);
      out_data_o  = out_valid_o ? head.data : '0;
      out_ts_o    = out_valid_o ? head.ts   : '0;
      level_o     = count;
      overflow_o  = overflow_q;
   end

endmodule
